// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO-buffered issue stage feeding the ALU datapath.
// Holds DIVU for the divider latency and gates MFHI/MFLO on HiLo settling.
module alu_issue_queue #(
  parameter int DEPTH      = 4,
  parameter int DIV_CYCLES = 32,
  parameter int HILO_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dataA,
  input  logic [31:0] in_dataB,
  input  logic [5:0]  in_signal,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  Signal,
  output logic        res_valid,
  output logic        div_busy,
  output logic        illegal
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_OR   = 6'd37;
  localparam logic [5:0] OP_ADD  = 6'd32;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_SLT  = 6'd42;
  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_SLL  = 6'd0;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;
  localparam logic [5:0] OP_IDLE = 6'h3f;

  localparam logic [6:0] DIV_LOAD = 7'(DIV_CYCLES - 1);
  localparam logic [1:0] HL_LOAD  = 2'(HILO_LAT);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
  } op_t;

  function automatic logic is_legal(input logic [5:0] s);
    case (s)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT,
      OP_SRL, OP_SLL, OP_DIVU, OP_MFHI,
      OP_MFLO: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_mf(input logic [5:0] s);
    is_mf = (s == OP_MFHI) || (s == OP_MFLO);
  endfunction

  op_t         mem [DEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;
  op_t         iss;
  op_t         iss_n;
  op_t         head;
  logic [6:0]  div_cnt;
  logic [6:0]  div_cnt_n;
  logic [1:0]  guard;
  logic [1:0]  guard_n;
  logic [1:0]  guard_eff;
  logic        busy_n;
  logic        ill_n;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        rel;
  logic        s_hold;
  logic        s_empty;
  logic        s_ill;
  logic        s_wait;

  assign full  = (wptr[PW-1:0] == rptr[PW-1:0]) &&
                 (wptr[PW] != rptr[PW]);
  assign empty = (wptr == rptr);

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem[rptr[PW-1:0]];

  assign dataA  = iss.a;
  assign dataB  = iss.b;
  assign Signal = iss.sig;

  assign res_valid = is_legal(iss.sig) &&
                     (iss.sig != OP_DIVU) && !div_busy;

  // The release edge already counts as the first guarded cycle.
  assign rel       = div_busy && (div_cnt == 7'd0);
  assign guard_eff = rel ? HL_LOAD : guard;

  assign s_hold  = div_busy && !rel;
  assign s_empty = !s_hold && empty;
  assign s_ill   = !s_hold && !empty &&
                   !is_legal(head.sig);
  assign s_wait  = !s_hold && !empty &&
                   is_legal(head.sig) &&
                   is_mf(head.sig) &&
                   (guard_eff != 2'd0);

  always_comb begin
    iss_n     = iss;
    busy_n    = 1'b0;
    div_cnt_n = 7'd0;
    ill_n     = 1'b0;
    pop       = 1'b0;
    guard_n   = (guard_eff != 2'd0) ?
                guard_eff - 2'd1 : 2'd0;
    unique case (1'b1)
      s_hold: begin
        busy_n    = 1'b1;
        div_cnt_n = div_cnt - 7'd1;
      end
      s_empty, s_wait: begin
        iss_n.sig = OP_IDLE;
      end
      s_ill: begin
        iss_n.sig = OP_IDLE;
        pop       = 1'b1;
        ill_n     = 1'b1;
      end
      default: begin
        iss_n = head;
        pop   = 1'b1;
        if (head.sig == OP_DIVU) begin
          busy_n    = 1'b1;
          div_cnt_n = DIV_LOAD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[PW-1:0]] <= '{in_dataA, in_dataB, in_signal};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr     <= '0;
      rptr     <= '0;
      iss      <= '{32'd0, 32'd0, OP_IDLE};
      div_busy <= 1'b0;
      div_cnt  <= 7'd0;
      guard    <= 2'd0;
      illegal  <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      iss      <= iss_n;
      div_busy <= busy_n;
      div_cnt  <= div_cnt_n;
      guard    <= guard_n;
      illegal  <= ill_n;
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: scoreboard bench for alu_issue_queue.
// Two instances cover HILO_LAT=1 (DIV 32) and HILO_LAT=2 (DIV 8).
module tb_alu_issue_queue;
  localparam int DC1 = 32;
  localparam int HL1 = 1;
  localparam int DC2 = 8;
  localparam int HL2 = 2;

  localparam logic [5:0] IDLE = 6'h3f;
  localparam logic [5:0] AND_ = 6'd36;
  localparam logic [5:0] OR_  = 6'd37;
  localparam logic [5:0] ADD  = 6'd32;
  localparam logic [5:0] SUB  = 6'd34;
  localparam logic [5:0] SLT  = 6'd42;
  localparam logic [5:0] SRL  = 6'd2;
  localparam logic [5:0] SLL  = 6'd0;
  localparam logic [5:0] DIVU = 6'd27;
  localparam logic [5:0] MFHI = 6'd16;
  localparam logic [5:0] MFLO = 6'd18;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sig;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [5:0]  in_sig;
  logic [31:0] da;
  logic [31:0] db;
  logic [5:0]  sig;
  logic        res_valid;
  logic        div_busy;
  logic        illegal;

  logic        v2;
  logic        rdy2;
  logic [31:0] a2;
  logic [31:0] b2;
  logic [5:0]  s2;
  logic [31:0] da2;
  logic [31:0] db2;
  logic [5:0]  sig2;
  logic        rv2;
  logic        busy2;
  logic        ill2;

  int total  = 0;
  int passed = 0;
  op_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue_queue #(
    .DEPTH(4), .DIV_CYCLES(DC1), .HILO_LAT(HL1)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dataA(in_a), .in_dataB(in_b), .in_signal(in_sig),
    .dataA(da), .dataB(db), .Signal(sig),
    .res_valid(res_valid), .div_busy(div_busy),
    .illegal(illegal)
  );

  alu_issue_queue #(
    .DEPTH(4), .DIV_CYCLES(DC2), .HILO_LAT(HL2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(v2), .in_ready(rdy2),
    .in_dataA(a2), .in_dataB(b2), .in_signal(s2),
    .dataA(da2), .dataB(db2), .Signal(sig2),
    .res_valid(rv2), .div_busy(busy2),
    .illegal(ill2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    {in_a, in_b, in_sig} = '0;
    v2 = 1'b0;
    {a2, b2, s2} = '0;
    repeat (2) step();
    total++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passed++;
    total++; if (sig !== IDLE) $display("FAIL rst_signal: got %0d want %0d", sig, IDLE); else passed++;
    total++; if (da !== 32'd0 || db !== 32'd0) $display("FAIL rst_data: got %0h/%0h want 0/0", da, db); else passed++;
    total++; if (res_valid !== 1'b0) $display("FAIL rst_res_valid: got %b want 0", res_valid); else passed++;
    total++; if (div_busy !== 1'b0) $display("FAIL rst_div_busy: got %b want 0", div_busy); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL rst_illegal: got %b want 0", illegal); else passed++;
    total++; if (rdy2 !== 1'b1 || sig2 !== IDLE) $display("FAIL rst_dut2: got %b/%0d want 1/%0d", rdy2, sig2, IDLE); else passed++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_single();
    op_t o;
    op_t e;
    o = '{32'd5, 32'd7, ADD};
    in_valid = 1'b1;
    {in_a, in_b, in_sig} = o;
    exp_q.push_back(o);
    step();
    in_valid = 1'b0;
    total++; if (sig !== IDLE) $display("FAIL single_early: got %0d want %0d", sig, IDLE); else passed++;
    step();
    e = exp_q.pop_front();
    total++; if (sig !== e.sig) $display("FAIL single_sig: got %0d want %0d", sig, e.sig); else passed++;
    total++; if (da !== e.a || db !== e.b) $display("FAIL single_data: got %0d/%0d want %0d/%0d", da, db, e.a, e.b); else passed++;
    total++; if (res_valid !== 1'b1) $display("FAIL single_rv: got %b want 1", res_valid); else passed++;
    step();
    total++; if (sig !== IDLE || res_valid !== 1'b0) $display("FAIL single_idle: got %0d/%b want %0d/0", sig, res_valid, IDLE); else passed++;
    total++; if (da !== 32'd5) $display("FAIL single_hold_a: got %0d want 5", da); else passed++;
  endtask

  task automatic test_back_to_back();
    op_t ops[6];
    op_t e;
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int divcnt = 0;
    int first = -1;
    int last = -1;
    logic rdy;
    logic [5:0] prev = IDLE;
    ops[0] = '{32'd50, 32'd5, DIVU};
    ops[1] = '{32'hF0F0, 32'h0FF0, AND_};
    ops[2] = '{32'h1111, 32'h2222, OR_};
    ops[3] = '{32'd3, 32'd9, SLT};
    ops[4] = '{32'h80, 32'd4, SRL};
    ops[5] = '{32'h1, 32'd31, SLL};
    while (got < 6 && cyc < 200) begin
      in_valid = (idx < 6);
      if (idx < 6) {in_a, in_b, in_sig} = ops[idx];
      rdy = in_ready;
      step();
      cyc++;
      if (idx < 6 && rdy) begin
        exp_q.push_back(ops[idx]);
        idx++;
        if (idx == 5) begin
          total++; if (in_ready !== 1'b0) $display("FAIL b2b_full: got %b want 0", in_ready); else passed++;
        end
      end
      if (sig === DIVU) begin
        divcnt++;
        total++; if (div_busy !== 1'b1 || res_valid !== 1'b0) $display("FAIL b2b_div_hold: got busy=%b rv=%b want 1/0", div_busy, res_valid); else passed++;
      end
      if (sig !== IDLE && !(sig === DIVU && prev === DIVU)) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL b2b_extra: got %0d want none", sig);
        end else begin
          e = exp_q.pop_front();
          got++;
          if (got == 2) first = cyc;
          if (got == 6) last = cyc;
          total++; if ({da, db, sig} !== e) $display("FAIL b2b_order: got %0h/%0h/%0d want %0h/%0h/%0d", da, db, sig, e.a, e.b, e.sig); else passed++;
          total++; if (res_valid !== (e.sig != DIVU)) $display("FAIL b2b_rv: got %b want %b", res_valid, e.sig != DIVU); else passed++;
        end
      end
      prev = sig;
    end
    in_valid = 1'b0;
    total++; if (got != 6) $display("FAIL b2b_timeout: got %0d ops want 6", got); else passed++;
    total++; if (divcnt != DC1) $display("FAIL b2b_div_len: got %0d want %0d", divcnt, DC1); else passed++;
    total++; if (last - first != 4) $display("FAIL b2b_rate: got %0d want 4", last - first); else passed++;
    step();
    total++; if (sig !== IDLE || in_ready !== 1'b1) $display("FAIL b2b_drain: got %0d/%b want %0d/1", sig, in_ready, IDLE); else passed++;
  endtask

  task automatic test_divu_hilo();
    op_t ops[3];
    op_t e;
    logic [5:0] want;
    int mfk;
    ops[0] = '{32'd100, 32'd7, DIVU};
    ops[1] = '{32'd100, 32'd7, MFLO};
    ops[2] = '{32'd100, 32'd7, MFHI};
    mfk = 2 + DC1 + HL1;
    for (int k = 1; k <= 40; k++) begin
      in_valid = (k <= 3);
      if (k <= 3) begin
        {in_a, in_b, in_sig} = ops[k-1];
        exp_q.push_back(ops[k-1]);
      end
      step();
      if (k >= 2 && k < 2 + DC1) want = DIVU;
      else if (k == mfk) want = MFLO;
      else if (k == mfk + 1) want = MFHI;
      else want = IDLE;
      total++; if (sig !== want || div_busy !== (want == DIVU) || res_valid !== (want == MFLO || want == MFHI)) $display("FAIL hilo_trace k=%0d: got %0d/%b/%b want %0d/%b/%b", k, sig, div_busy, res_valid, want, want == DIVU, want == MFLO || want == MFHI); else passed++;
      if (k == 2 || k == mfk || k == mfk + 1) begin
        e = exp_q.pop_front();
        total++; if ({da, db, sig} !== e) $display("FAIL hilo_data k=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, da, db, sig, e.a, e.b, e.sig); else passed++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_guard_bypass();
    op_t ops[3];
    op_t e;
    logic [5:0] want;
    int subk;
    int mfk;
    ops[0] = '{32'd40, 32'd6, DIVU};
    ops[1] = '{32'd9, 32'd3, SUB};
    ops[2] = '{32'd0, 32'd0, MFHI};
    subk = 2 + DC2;
    mfk = (2 + DC2 + HL2 > subk + 1) ? 2 + DC2 + HL2 : subk + 1;
    for (int k = 1; k <= 18; k++) begin
      v2 = (k <= 3);
      if (k <= 3) begin
        {a2, b2, s2} = ops[k-1];
        exp_q.push_back(ops[k-1]);
      end
      step();
      if (k >= 2 && k < subk) want = DIVU;
      else if (k == subk) want = SUB;
      else if (k == mfk) want = MFHI;
      else want = IDLE;
      total++; if (sig2 !== want || busy2 !== (want == DIVU) || rv2 !== (want == SUB || want == MFHI)) $display("FAIL guard_trace k=%0d: got %0d/%b/%b want %0d/%b/%b", k, sig2, busy2, rv2, want, want == DIVU, want == SUB || want == MFHI); else passed++;
      if (k == 2 || k == subk || k == mfk) begin
        e = exp_q.pop_front();
        total++; if ({da2, db2, sig2} !== e) $display("FAIL guard_data k=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", k, da2, db2, sig2, e.a, e.b, e.sig); else passed++;
      end
    end
    v2 = 1'b0;
  endtask

  task automatic test_illegal();
    op_t bad;
    op_t o;
    op_t e;
    logic [5:0] want;
    bad = '{32'd1, 32'd2, 6'd63};
    o = '{32'd3, 32'd12, OR_};
    for (int k = 1; k <= 5; k++) begin
      in_valid = (k <= 2);
      if (k == 1) {in_a, in_b, in_sig} = bad;
      if (k == 2) begin
        {in_a, in_b, in_sig} = o;
        exp_q.push_back(o);
      end
      step();
      want = (k == 3) ? OR_ : IDLE;
      total++; if (illegal !== (k == 2)) $display("FAIL ill_pulse k=%0d: got %b want %b", k, illegal, k == 2); else passed++;
      total++; if (sig !== want || res_valid !== (k == 3)) $display("FAIL ill_sig k=%0d: got %0d/%b want %0d/%b", k, sig, res_valid, want, k == 3); else passed++;
      if (k == 3) begin
        e = exp_q.pop_front();
        total++; if (da !== e.a || db !== e.b) $display("FAIL ill_data: got %0d/%0d want %0d/%0d", da, db, e.a, e.b); else passed++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    op_t ops[3];
    ops[0] = '{32'd50, 32'd5, DIVU};
    ops[1] = '{32'd6, 32'd7, AND_};
    ops[2] = '{32'd8, 32'd9, ADD};
    for (int k = 1; k <= 12; k++) begin
      in_valid = (k <= 3);
      if (k <= 3) {in_a, in_b, in_sig} = ops[k-1];
      step();
    end
    in_valid = 1'b0;
    total++; if (div_busy !== 1'b1 || sig !== DIVU) $display("FAIL mid_pre: got %b/%0d want 1/%0d", div_busy, sig, DIVU); else passed++;
    #3 reset = 1'b0;
    #1;
    total++; if (sig !== IDLE || da !== 32'd0 || db !== 32'd0) $display("FAIL mid_async_out: got %0d/%0d/%0d want %0d/0/0", sig, da, db, IDLE); else passed++;
    total++; if (div_busy !== 1'b0 || res_valid !== 1'b0 || illegal !== 1'b0) $display("FAIL mid_async_flags: got %b/%b/%b want 0/0/0", div_busy, res_valid, illegal); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL mid_async_ready: got %b want 1", in_ready); else passed++;
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (sig !== IDLE || in_ready !== 1'b1) $display("FAIL mid_after k=%0d: got %0d/%b want %0d/1", k, sig, in_ready, IDLE); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    step();
    test_back_to_back();
    step();
    test_divu_hilo();
    step();
    test_guard_bypass();
    step();
    test_illegal();
    step();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream issue stage for the ALU datapath. It buffers incoming ALU operations (operand pair plus 6-bit function code) in a small FIFO and presents exactly one operation at a time on the dataA/dataB/Signal inputs of the ALU datapath. It holds a DIVU stable for the full divider latency, and stalls MFHI/MFLO until the HiLo result has settled. It also flags, per cycle, when the datapath Output carries a valid result.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- DIV_CYCLES, 32: cycles a DIVU must be held on the datapath inputs; range 1..64.
- HILO_LAT, 1: extra cycles after DIVU release before MFHI/MFLO may issue; range 0..3.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: upstream offers an operation.
- in_ready, out, 1: FIFO can accept; equals !full.
- in_dataA, in, 32: operand A.
- in_dataB, in, 32: operand B.
- in_signal, in, 6: function code.
- dataA, out, 32: registered operand A to the datapath.
- dataB, out, 32: registered operand B to the datapath.
- Signal, out, 6: registered function code to the datapath.
- res_valid, out, 1: datapath Output is a valid result this cycle.
- div_busy, out, 1: a DIVU is being held.
- illegal, out, 1: one-cycle pulse when an unsupported code is discarded.

## Operation

- Legal codes: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SRL 2, SLL 0, DIVU 27, MFHI 16, MFLO 18. All other codes are illegal.
- IDLE code is 6'b111111. It is driven on Signal whenever no operation is issued. dataA and dataB hold their last values.
- Push: occurs when in_valid && in_ready at a rising edge. There is no bypass: in_ready depends only on FIFO occupancy, never on a same-cycle pop.
- Pop/issue decision at each edge, in priority order:
  - If div_busy: hold the issue registers and decrement the DIV counter.
  - Else if FIFO empty: load IDLE.
  - Else if head is illegal: pop it, load IDLE, pulse illegal.
  - Else if head is MFHI/MFLO and the HiLo guard counter is nonzero: do not pop, load IDLE.
  - Else: pop the head into dataA/dataB/Signal.
- DIVU issue: counter loads DIV_CYCLES-1 and div_busy is set in the same edge. The op is held while the counter is nonzero. Once the counter is 0, the next edge releases it, clears div_busy, and loads the HiLo guard counter with HILO_LAT. The guard decrements every cycle it is nonzero.
- Non-MFHI/MFLO ops may issue while the guard is nonzero.
- res_valid = 1 iff Signal holds a legal non-DIVU code. It is always 0 while div_busy.
- Counters are 7-bit (DIV) and 2-bit (guard) and saturate at 0.
- FIFO pointers are log2(DEPTH)+1 bits with wrap-around. full when the low bits match and the MSBs differ; empty when equal.

## Timing

- Reset values (asynchronous, on reset low):
  - FIFO empty, in_ready=1.
  - dataA=0, dataB=0, Signal=IDLE.
  - res_valid=0, div_busy=0, illegal=0.
  - Both counters 0.
- Reset mid-DIVU: the op is abandoned immediately and the FIFO contents are discarded.
- Latency: an op pushed at edge k into an empty, non-busy queue appears on the datapath after edge k+1. Throughput is one op per cycle.
- A DIVU occupies Signal for exactly DIV_CYCLES cycles. The next op appears on the following cycle.
- The first MFHI/MFLO after a DIVU appears no earlier than HILO_LAT cycles after DIVU release.
- Push and pop may occur on the same edge. Occupancy is unchanged; no data is lost at full-minus-one or at pointer wrap.
- illegal is registered and lasts exactly one cycle per discarded entry.

## Test plan

- Reset, then push ADD (A=5, B=7) -> after edge 2, Signal=32, dataA=5, dataB=7, res_valid=1. The following cycle Signal=IDLE and res_valid=0.
- Push 5 ops back-to-back while the head is a DIVU with DEPTH=4 -> in_ready=0 after the 4th push. The 5th op is held upstream and accepted when the FIFO drains. Order is preserved through pointer wrap.
- DIVU (A=100, B=7), then MFLO, MFHI, with DIV_CYCLES=32 and HILO_LAT=1 -> Signal=27 for 32 cycles with div_busy=1 and res_valid=0. Then 1 IDLE cycle, then MFLO (Output=14), then MFHI (Output=2).
- DIVU followed by SUB (A=9, B=3), HILO_LAT=2 -> SUB issues immediately after DIVU release with res_valid=1. MFHI queued behind it waits until the guard expires.
- Push code 63, then OR -> illegal pulses for 1 cycle and nothing is issued for code 63. OR issues on the next cycle.
- Assert reset low 10 cycles into a DIVU with 2 queued ops -> all outputs return to reset values asynchronously. After release the queue is empty and in_ready=1.
